tdc_meas_ctrl: RTL and testbench
================================

// Module: tdc_meas_ctrl
// PURPOSE
//  Measurement sequencer/accumulator directly downstream of the TDC delay-line block.
//  - Clears the TDC latches and fires a start trigger.
//  - Waits for the stop event and samples the thermometer count dec.
//  - Accumulates NR_SAMPLES shots and hands the sum/average to the readout logic
//    over a valid/ready handshake.
// PARAMETERS
//  NR_DELAY_CELLS  3     delay cells in the TDC; DEC_W = $clog2(NR_DELAY_CELLS)+1
//  NR_SAMPLES      4     shots per measurement; power of 2, >=1; LOG2_NS = $clog2(NR_SAMPLES)
//  CLR_CYC         2     cycles tdc_clr_n is held low before each shot (>=1)
//  SETTLE_CYC      2     cycles waited after the synchronised stop edge before sampling dec (>=1)
//  TIMEOUT_CYC     255   max cycles in WAIT_STOP before abort (>=1)
// PORTS
//  sclk        in   1              system clock, all logic posedge
//  R           in   1              asynchronous active-low reset
//  meas_req    in   1              pulse/level; start a measurement, sampled only in IDLE
//  meas_busy   out  1              high in every state except IDLE
//  tdc_clr_n   out  1              drives the TDC R input; low = latches cleared
//  tdc_go      out  1              one-cycle start trigger to the start-pulse source
//  stop_flag   in   1              asynchronous stop indication from the TDC side
//  dec         in   DEC_W          TDC thermometer count, static while latches hold
//  res_valid   out  1              result available, held until accepted
//  res_ready   in   1              consumer accepts the result on res_valid&res_ready
//  res_sum     out  DEC_W+LOG2_NS  sum of the NR_SAMPLES dec samples
//  res_avg     out  DEC_W          res_sum >> LOG2_NS, truncated
//  res_err     out  1              measurement aborted by timeout
// BEHAVIOUR
//  Reset values (R low): state IDLE, all counters/acc 0.
//  - tdc_clr_n=0, tdc_go=0, res_valid=0, res_sum=0, res_avg=0, res_err=0, meas_busy=0.
//  stop_flag path: 2-FF synchroniser, then rising-edge detect (sync'd rise = 3rd cycle after the async edge).
//  FSM states and transitions:
//  - IDLE: tdc_clr_n=0. On meas_req=1 -> CLEAR; clear acc, shot counter and res_err.
//  - CLEAR: tdc_clr_n=0 for CLR_CYC cycles -> ARM.
//  - ARM: tdc_clr_n=1, tdc_go=1 for exactly this one cycle -> WAIT_STOP; timeout counter=0.
//  - WAIT_STOP: tdc_clr_n=1.
//    - On stop rise -> SETTLE.
//    - Otherwise, when the timeout counter reaches TIMEOUT_CYC -> DONE with res_err=1, res_sum=0, res_avg=0.
//  - SETTLE: SETTLE_CYC cycles -> SAMPLE.
//  - SAMPLE (1 cycle): acc += dec (zero-extended), shot++.
//    - shot==NR_SAMPLES -> DONE, loading res_sum=acc+dec and res_avg.
//    - Otherwise -> CLEAR.
//  - DONE: res_valid=1; tdc_clr_n=0. On res_ready=1 -> IDLE; res_valid drops the next cycle.
//  Boundary conditions:
//  - meas_req outside IDLE is ignored; no queuing.
//  - A stop rise outside WAIT_STOP is ignored.
//  - A stop rise in the same cycle the timeout is reached: the stop wins (-> SETTLE).
//  - res_ready without res_valid has no effect.
//  - The accumulator cannot overflow by construction of its width; max sum = NR_SAMPLES*(2^DEC_W-1).
//  - R asserted mid-measurement aborts immediately to the reset values; no partial result is emitted.
//  - res_* outputs hold their last value until the next DONE load.
// CONFIGURATION
//  TDC_MINMAX_EN defined:
//  - Adds outputs res_min and res_max (each DEC_W): min/max of the dec samples over the measurement.
//  - res_min resets to all-ones and res_max to 0 at measurement start; both are 0 on timeout.
//  TDC_MINMAX_EN undefined: the ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package tdc_pkg:
//  - state enum {IDLE,CLEAR,ARM,WAIT_STOP,SETTLE,SAMPLE,DONE};
//  - function dec_width(nr_cells) = $clog2(nr_cells)+1.
//  Sub-module tdc_sync2: 2-FF synchroniser with async active-low reset, reset value 0.
//  Everything else is flat in tdc_meas_ctrl.
// TESTING (defaults: DEC_W=3, NR_SAMPLES=4, CLR_CYC=2, SETTLE_CYC=2)
//  1 Reset: R low mid-WAIT_STOP -> all outputs at reset values next edge, meas_busy=0, no res_valid.
//  2 Basic: req, dec=5 on each shot, stop each shot -> 4 tdc_go pulses; res_sum=20, res_avg=5, res_err=0.
//  3 Truncation: dec=1,2,2,2 -> res_sum=7, res_avg=1; with TDC_MINMAX_EN, res_min=1, res_max=2.
//  4 Timeout: TIMEOUT_CYC=8, no stop -> res_valid after 8 WAIT_STOP cycles, res_err=1, res_sum=0.
//  5 Backpressure: res_ready low 10 cycles -> res_valid and res_* stable; meas_req ignored; IDLE after ready.
//  6 Race: stop rise in the timeout cycle -> sample taken, res_err=0; a second meas_req during busy is ignored.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared state encoding and width helper for the TDC measurement controller.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ARM,
    WAIT_STOP,
    SETTLE,
    SAMPLE,
    DONE
  } tdc_state_e;

  // Thermometer count width needed to represent 0..nr_cells.
  function automatic int unsigned dec_width(input int unsigned nr_cells);
    return 32'($clog2(nr_cells) + 1);
  endfunction

endpackage

// File: rtl/tdc_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module tdc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clear/arm/stop/sample over NR_SAMPLES shots, then
// hands sum and average to readout. Define TDC_MINMAX_EN to add res_min/res_max.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter  int unsigned NR_DELAY_CELLS = 3,
  parameter  int unsigned NR_SAMPLES     = 4,
  parameter  int unsigned CLR_CYC        = 2,
  parameter  int unsigned SETTLE_CYC     = 2,
  parameter  int unsigned TIMEOUT_CYC    = 255,
  localparam int unsigned DEC_W          = dec_width(NR_DELAY_CELLS),
  localparam int unsigned LOG2_NS        = $clog2(NR_SAMPLES),
  localparam int unsigned SUM_W          = DEC_W + LOG2_NS
) (
  input  logic             sclk,
  input  logic             R,
  input  logic             meas_req,
  output logic             meas_busy,
  output logic             tdc_clr_n,
  output logic             tdc_go,
  input  logic             stop_flag,
  input  logic [DEC_W-1:0] dec,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [DEC_W-1:0] res_avg,
`ifdef TDC_MINMAX_EN
  output logic [DEC_W-1:0] res_min,
  output logic [DEC_W-1:0] res_max,
`endif
  output logic             res_err
);

  localparam int unsigned SHOT_W  = (LOG2_NS > 0) ? LOG2_NS : 1;
  localparam int unsigned CYC_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  tdc_state_e        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [SHOT_W-1:0] shot_q, shot_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  res_sum_q, res_sum_d;
  logic [DEC_W-1:0]  res_avg_q, res_avg_d;
  logic              res_err_q, res_err_d;
  logic              meas_busy_q, tdc_clr_n_q, tdc_go_q, res_valid_q;
  logic [SUM_W-1:0]  sum_c;
  logic              stop_sync;
  logic              stop_prev_q;
  logic              stop_rise;
`ifdef TDC_MINMAX_EN
  logic [DEC_W-1:0]  min_q, min_d, max_q, max_d;
  logic [DEC_W-1:0]  res_min_q, res_min_d, res_max_q, res_max_d;
  logic [DEC_W-1:0]  min_c, max_c;
`endif

  // Stop indication crosses into sclk; only its rising edge is acted on.
  tdc_sync2 u_stop_sync (
    .clk   (sclk),
    .rst_n (R),
    .d_i   (stop_flag),
    .q_o   (stop_sync)
  );

  assign stop_rise = stop_sync & ~stop_prev_q;
  assign sum_c     = acc_q + SUM_W'(dec);
`ifdef TDC_MINMAX_EN
  assign min_c     = (dec < min_q) ? dec : min_q;
  assign max_c     = (dec > max_q) ? dec : max_q;
`endif

  always_ff @(posedge sclk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    tmo_d     = tmo_q;
    shot_d    = shot_q;
    acc_d     = acc_q;
    res_sum_d = res_sum_q;
    res_avg_d = res_avg_q;
    res_err_d = res_err_q;
`ifdef TDC_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (meas_req) begin
          state_d   = CLEAR;
          cyc_d     = '0;
          shot_d    = '0;
          acc_d     = '0;
          res_err_d = 1'b0;
`ifdef TDC_MINMAX_EN
          min_d     = '1;
          max_d     = '0;
`endif
        end
      end
      CLEAR: begin
        if (cyc_q == CYC_W'(CLR_CYC - 1)) begin
          state_d = ARM;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ARM: begin
        state_d = WAIT_STOP;
        tmo_d   = '0;
      end
      WAIT_STOP: begin
        // A stop edge arriving in the timeout cycle still wins.
        if (stop_rise) begin
          state_d = SETTLE;
          cyc_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d   = DONE;
          res_err_d = 1'b1;
          res_sum_d = '0;
          res_avg_d = '0;
`ifdef TDC_MINMAX_EN
          res_min_d = '0;
          res_max_d = '0;
`endif
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          state_d = SAMPLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      SAMPLE: begin
        acc_d  = sum_c;
        shot_d = shot_q + SHOT_W'(1);
`ifdef TDC_MINMAX_EN
        min_d  = min_c;
        max_d  = max_c;
`endif
        if (shot_q == SHOT_W'(NR_SAMPLES - 1)) begin
          state_d   = DONE;
          res_sum_d = sum_c;
          res_avg_d = DEC_W'(sum_c >> LOG2_NS);
`ifdef TDC_MINMAX_EN
          res_min_d = min_c;
          res_max_d = max_c;
`endif
        end else begin
          state_d = CLEAR;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the next state so they line up with state_q.
  always_ff @(posedge sclk or negedge R) begin
    if (!R) begin
      cyc_q       <= '0;
      tmo_q       <= '0;
      shot_q      <= '0;
      acc_q       <= '0;
      res_sum_q   <= '0;
      res_avg_q   <= '0;
      res_err_q   <= 1'b0;
      stop_prev_q <= 1'b0;
      meas_busy_q <= 1'b0;
      tdc_clr_n_q <= 1'b0;
      tdc_go_q    <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef TDC_MINMAX_EN
      min_q       <= '1;
      max_q       <= '0;
      res_min_q   <= '0;
      res_max_q   <= '0;
`endif
    end else begin
      cyc_q       <= cyc_d;
      tmo_q       <= tmo_d;
      shot_q      <= shot_d;
      acc_q       <= acc_d;
      res_sum_q   <= res_sum_d;
      res_avg_q   <= res_avg_d;
      res_err_q   <= res_err_d;
      stop_prev_q <= stop_sync;
      meas_busy_q <= (state_d != IDLE);
      tdc_clr_n_q <= !(state_d inside {IDLE, CLEAR, DONE});
      tdc_go_q    <= (state_d == ARM);
      res_valid_q <= (state_d == DONE);
`ifdef TDC_MINMAX_EN
      min_q       <= min_d;
      max_q       <= max_d;
      res_min_q   <= res_min_d;
      res_max_q   <= res_max_d;
`endif
    end
  end

  assign meas_busy = meas_busy_q;
  assign tdc_clr_n = tdc_clr_n_q;
  assign tdc_go    = tdc_go_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_avg   = res_avg_q;
  assign res_err   = res_err_q;
`ifdef TDC_MINMAX_EN
  assign res_min   = res_min_q;
  assign res_max   = res_max_q;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomised bench for tdc_meas_ctrl: a behavioural TDC drives stop/dec and a
// shot-level model predicts each measurement's result.
module tb_tdc_meas_ctrl;

  localparam int unsigned NS      = 4;
  localparam int unsigned CLR     = 2;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TMO     = 8;
  localparam int unsigned DEC_W   = 3;
  localparam int unsigned LOG2_NS = 2;
  localparam int unsigned SUM_W   = DEC_W + LOG2_NS;

  logic             sclk = 1'b0;
  logic             R = 1'b0;
  logic             meas_req = 1'b0;
  logic             stop_flag = 1'b0;
  logic             res_ready = 1'b0;
  logic [DEC_W-1:0] dec = '0;
  logic             meas_busy, tdc_clr_n, tdc_go, res_valid, res_err;
  logic [SUM_W-1:0] res_sum;
  logic [DEC_W-1:0] res_avg;
`ifdef TDC_MINMAX_EN
  logic [DEC_W-1:0] res_min, res_max;
`endif

  always #5 sclk = ~sclk;

  tdc_meas_ctrl #(
    .NR_DELAY_CELLS (3),
    .NR_SAMPLES     (NS),
    .CLR_CYC        (CLR),
    .SETTLE_CYC     (SETTLE),
    .TIMEOUT_CYC    (TMO)
  ) dut (
    .sclk      (sclk),
    .R         (R),
    .meas_req  (meas_req),
    .meas_busy (meas_busy),
    .tdc_clr_n (tdc_clr_n),
    .tdc_go    (tdc_go),
    .stop_flag (stop_flag),
    .dec       (dec),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_avg   (res_avg),
`ifdef TDC_MINMAX_EN
    .res_min   (res_min),
    .res_max   (res_max),
`endif
    .res_err   (res_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  // Per shot: cycles after tdc_go until stop is driven (-1 = never), and dec value.
  int plan_d[NS];
  int plan_v[NS];
  int go_cnt, last_go_tick, tick_n, clr_low_run, clr_bad, cur_shot;
  int cd = -1;
  int st = -1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // TDC latches hold a garbage count right after stop and settle to the final value later.
  task automatic raise_stop();
    stop_flag = 1'b1;
    dec       = ~DEC_W'(plan_v[cur_shot]);
    st        = 5;
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
    tick_n++;
    if (!tdc_clr_n) begin
      stop_flag = 1'b0;
      dec       = '0;
      cd        = -1;
      st        = -1;
    end else begin
      if (st > 0) begin
        st--;
        if (st == 0) dec = DEC_W'(plan_v[cur_shot]);
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) raise_stop();
      end
    end
    if (tdc_go) begin
      if (go_cnt > 0 && clr_low_run != CLR) clr_bad++;
      go_cnt++;
      last_go_tick = tick_n;
      cur_shot = (go_cnt <= NS) ? go_cnt - 1 : NS - 1;
      if (plan_d[cur_shot] == 0) raise_stop();
      else if (plan_d[cur_shot] > 0) cd = plan_d[cur_shot];
    end
    clr_low_run = tdc_clr_n ? 0 : clr_low_run + 1;
  endtask

  // Stop is seen by the sequencer two cycles after it is driven; the sequencer
  // watches for TMO cycles following tdc_go.
  task automatic model(output int e_sum, output int e_err, output int e_gos,
                       output int e_min, output int e_max);
    e_sum = 0; e_err = 0; e_gos = 0; e_min = (1 << DEC_W) - 1; e_max = 0;
    for (int i = 0; i < NS; i++) begin
      e_gos++;
      if (plan_d[i] < 0 || plan_d[i] + 2 > int'(TMO)) begin
        e_err = 1; e_sum = 0; e_min = 0; e_max = 0;
        break;
      end
      e_sum += plan_v[i];
      if (plan_v[i] < e_min) e_min = plan_v[i];
      if (plan_v[i] > e_max) e_max = plan_v[i];
    end
  endtask

  task automatic run_meas(input string name, input int bp, input bit req_busy);
    int e_sum, e_err, e_gos, e_min, e_max, n;
    bit stable;
    logic [SUM_W-1:0] s_sum;
    logic [DEC_W-1:0] s_avg;
    model(e_sum, e_err, e_gos, e_min, e_max);
    n = 0;
    while (meas_busy && n < 50) begin tick(); n++; end
    go_cnt = 0; clr_bad = 0;
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    check({name, "_busy"}, meas_busy, 1);
    n = 0;
    while (!res_valid && n < 400) begin
      meas_req = req_busy && (n == 3);
      tick();
      n++;
    end
    meas_req = 1'b0;
    if (!res_valid) begin
      check({name, "_valid_timeout"}, 0, 1);
      return;
    end
    check({name, "_sum"}, res_sum, e_sum);
    check({name, "_avg"}, res_avg, e_sum >> LOG2_NS);
    check({name, "_err"}, res_err, e_err);
    check({name, "_go_pulses"}, go_cnt, e_gos);
    check({name, "_clr_len"}, clr_bad, 0);
    if (e_err != 0) check({name, "_tmo_latency"}, tick_n - last_go_tick, TMO + 1);
`ifdef TDC_MINMAX_EN
    check({name, "_min"}, res_min, e_min);
    check({name, "_max"}, res_max, e_max);
`endif
    s_sum = res_sum; s_avg = res_avg; stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      meas_req = (i == 2);
      tick();
      if (!res_valid || res_sum != s_sum || res_avg != s_avg || !meas_busy) stable = 1'b0;
    end
    meas_req = 1'b0;
    if (bp > 0) check({name, "_bp_stable"}, stable, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, "_valid_drop"}, res_valid, 0);
    check({name, "_idle"}, meas_busy, 0);
    if (req_busy || bp > 2) begin
      for (int i = 0; i < 3; i++) tick();
      check({name, "_no_queue"}, meas_busy, 0);
    end
  endtask

  task automatic set_plan(input int d0, input int d1, input int d2, input int d3,
                          input int v0, input int v1, input int v2, input int v3);
    plan_d[0] = d0; plan_d[1] = d1; plan_d[2] = d2; plan_d[3] = d3;
    plan_v[0] = v0; plan_v[1] = v1; plan_v[2] = v2; plan_v[3] = v3;
  endtask

  initial begin
    bit ok;
    tick_n = 0; go_cnt = 0; clr_low_run = 0; clr_bad = 0; cur_shot = 0; last_go_tick = 0;
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("rst_busy", meas_busy, 0);
    check("rst_clr_n", tdc_clr_n, 0);
    check("rst_go", tdc_go, 0);
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_err", res_err, 0);
    R = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    res_ready = 1'b0;
    check("ready_wo_valid", {meas_busy, res_valid}, 0);

    set_plan($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 4), 5, 5, 5, 5);
    run_meas("basic", 0, 0);
    set_plan(1, 0, 3, 2, 1, 2, 2, 2);
    run_meas("trunc", 0, 0);
    set_plan(-1, 0, 0, 0, 3, 3, 3, 3);
    run_meas("timeout", 0, 0);
    set_plan(2, 1, 0, 4, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7));
    run_meas("backpressure", 10, 1);
    set_plan(2, 6, 1, 3, 4, 6, 1, 3);
    run_meas("race_stop", 0, 1);
    set_plan(1, 1, 7, 0, 4, 6, 1, 3);
    run_meas("race_tmo", 0, 0);
    set_plan(0, 6, 0, 6, 7, 7, 7, 7);
    run_meas("max_sum", 0, 0);

    // Asynchronous reset while waiting for a stop that never comes.
    set_plan(-1, -1, -1, -1, 0, 0, 0, 0);
    go_cnt = 0;
    meas_req = 1'b1;
    tick();
    meas_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_busy", meas_busy, 1);
    check("pre_rst_clr_n", tdc_clr_n, 1);
    #2 R = 1'b0;
    #1;
    check("mid_rst_busy", meas_busy, 0);
    check("mid_rst_clr_n", tdc_clr_n, 0);
    check("mid_rst_sum", res_sum, 0);
    check("mid_rst_avg", res_avg, 0);
    tick();
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_go", tdc_go, 0);
    R = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (meas_busy || res_valid || tdc_go) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NS; i++) begin
        plan_d[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 7));
        plan_v[i] = $urandom_range(0, 7);
      end
      run_meas($sformatf("rnd%0d", r), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
